ls_cnt_sched: RTL and testbench

Run sequencer and readout scheduler for a bank of NCH error-counter channels in the latch/shift-register test fabric. On start it clears every channel, opens a measurement window of a programmed number of CLK cycles, snapshots all channel error counts at window close, then drains them one channel per beat over a valid/ready port to the shared host readout. An optional continuous mode re-arms automatically after each drain.

---
 rtl/ls_cnt_pkg.sv | 22 ++
 rtl/ls_cnt_win_timer.sv | 29 ++
 rtl/ls_cnt_sched.sv | 180 ++++++++++++++++++
 tb/tb_ls_cnt_sched.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ls_cnt_pkg.sv
// ls_cnt_pkg: shared state type and constants for the counter-channel run sequencer.
package ls_cnt_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StClr,
      StRun,
      StSnap,
      StDrain
   } ls_state_e;

   // Default number of cycles the channel clear is held per run.
   localparam int unsigned CLR_CYC_DEF = 4;

   // Header beat layout: {aborted, run_id}, zero-extended to the count width.
   localparam int unsigned RUN_ID_W      = 8;
   localparam int unsigned HDR_ABORT_BIT = RUN_ID_W;

   // Channel index width on the readout port.
   localparam int unsigned CH_IDX_W = 4;

endpackage

// File: rtl/ls_cnt_win_timer.sv
// ls_cnt_win_timer: loadable measurement-window down-counter.
// A load of zero is treated as one; expire is high in the last enabled cycle.
module ls_cnt_win_timer #(
   parameter int unsigned WIN_W = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             load,
   input  logic [WIN_W-1:0] load_val,
   input  logic             en,
   output logic             expire
);

   logic [WIN_W-1:0] cnt_q;

   // Load takes priority; otherwise count down while enabled, never below zero.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= (load_val == '0) ? WIN_W'(1) : load_val;
      end else if (en && (cnt_q != '0)) begin
         cnt_q <= cnt_q - WIN_W'(1);
      end
   end

   assign expire = en && (cnt_q == WIN_W'(1));

endmodule

// File: rtl/ls_cnt_sched.sv
// ls_cnt_sched: run sequencer and readout scheduler for a bank of error-counter channels.
// Clears all channels, times a measurement window, snapshots every count and drains the
// snapshot one channel per valid/ready beat. Define LS_HDR_EN to prepend a header beat
// carrying {aborted, run_id} to each drain.
module ls_cnt_sched
   import ls_cnt_pkg::*;
#(
   parameter int unsigned NCH     = 8,
   parameter int unsigned CW      = 12,
   parameter int unsigned WIN_W   = 32,
   parameter int unsigned CLR_CYC = CLR_CYC_DEF
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                start,
   input  logic                stop,
   input  logic                cont,
   input  logic [WIN_W-1:0]    win_len,
   input  logic [NCH*CW-1:0]   ch_err_cnt,
   output logic [NCH-1:0]      ch_rst,
   output logic                busy,
   output logic                done,
   output logic                rd_valid,
   input  logic                rd_ready,
   output logic [CH_IDX_W-1:0] rd_ch,
   output logic [CW-1:0]       rd_cnt,
   output logic                rd_hdr,
   output logic [RUN_ID_W-1:0] run_id
);

   localparam int unsigned ClrW = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;

   ls_state_e            state_q, state_d;
   logic [ClrW-1:0]      clr_cnt_q;
   logic [CH_IDX_W-1:0]  idx_q;
   logic [CW-1:0]        shadow_q [NCH];
   logic                 cont_q;
   logic                 done_q;
   logic [RUN_ID_W-1:0]  run_id_q;

   logic                 beat_hdr;
   logic [CW-1:0]        hdr_cnt;
   logic [CW-1:0]        ch_cnt;
   logic                 accept;
   logic                 last_beat;
   logic                 clr_end;
   logic                 enter_clr;
   logic                 win_expire;

   assign accept    = rd_valid && rd_ready;
   assign last_beat = accept && !beat_hdr && (idx_q == CH_IDX_W'(NCH - 1));
   assign clr_end   = (clr_cnt_q == ClrW'(CLR_CYC - 1));
   assign enter_clr = (state_d == StClr) && (state_q != StClr);

   ls_cnt_win_timer #(
      .WIN_W (WIN_W)
   ) u_win_timer (
      .CLK      (CLK),
      .RST      (RST),
      .load     (enter_clr),
      .load_val (win_len),
      .en       (state_q == StRun),
      .expire   (win_expire)
   );

   // Next-state decode; a stop during drain suppresses the continuous re-arm.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StClr;
         StClr:   if (clr_end) state_d = StRun;
         StRun:   if (stop || win_expire) state_d = StSnap;
         StSnap:  state_d = StDrain;
         StDrain: if (last_beat) state_d = (cont_q && !stop) ? StClr : StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Sequencer state, clear timing, drain index, completion pulse and run counter.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= StIdle;
         cont_q    <= 1'b0;
         clr_cnt_q <= '0;
         idx_q     <= '0;
         done_q    <= 1'b0;
         run_id_q  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == StIdle) begin
            if (start) cont_q <= cont && !stop;
         end else if (stop) begin
            cont_q <= 1'b0;
         end
         clr_cnt_q <= (state_q == StClr) ? clr_cnt_q + ClrW'(1) : '0;
         if (state_q == StSnap) begin
            idx_q <= '0;
         end else if (accept && !beat_hdr) begin
            idx_q <= idx_q + CH_IDX_W'(1);
         end
         done_q <= last_beat;
         if (last_beat) run_id_q <= run_id_q + RUN_ID_W'(1);
      end
   end

   // Snapshot every channel count in the single SNAP cycle; held until the next SNAP.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < int'(NCH); i++) shadow_q[i] <= '0;
      end else if (state_q == StSnap) begin
         for (int i = 0; i < int'(NCH); i++) shadow_q[i] <= ch_err_cnt[i*CW +: CW];
      end
   end

`ifdef LS_HDR_EN
   logic                   hdr_q;
   logic                   aborted_q;
   logic [HDR_ABORT_BIT:0] hdr_word;

   // Header is pending from the snapshot until its beat is taken; abort flag spans one run.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         hdr_q     <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         if (state_q == StSnap) begin
            hdr_q <= 1'b1;
         end else if (accept) begin
            hdr_q <= 1'b0;
         end
         if (enter_clr) begin
            aborted_q <= 1'b0;
         end else if ((state_q == StRun) && stop) begin
            aborted_q <= 1'b1;
         end
      end
   end

   // Header payload {aborted, run_id}, zero-extended to the count width.
   always_comb begin
      hdr_word                     = '0;
      hdr_word[HDR_ABORT_BIT]      = aborted_q;
      hdr_word[RUN_ID_W-1:0]       = run_id_q;
      hdr_cnt                      = CW'(hdr_word);
   end

   assign beat_hdr = hdr_q;
`else
   assign beat_hdr = 1'b0;
   assign hdr_cnt  = '0;
`endif

   // Select the shadow entry addressed by the drain index.
   always_comb begin
      ch_cnt = '0;
      for (int i = 0; i < int'(NCH); i++) begin
         if (idx_q == CH_IDX_W'(i)) ch_cnt = shadow_q[i];
      end
   end

   // Readout port; fields are zero whenever no beat is offered.
   always_comb begin
      rd_valid = (state_q == StDrain);
      rd_hdr   = rd_valid && beat_hdr;
      rd_ch    = '0;
      rd_cnt   = '0;
      if (rd_hdr) begin
         rd_cnt = hdr_cnt;
      end else if (rd_valid) begin
         rd_ch  = idx_q;
         rd_cnt = ch_cnt;
      end
   end

   assign ch_rst = {NCH{state_q == StClr}};
   assign busy   = (state_q != StIdle);
   assign done   = done_q;
   assign run_id = run_id_q;

endmodule

// File: tb/tb_ls_cnt_sched.sv
// tb_ls_cnt_sched: randomized scoreboard bench for ls_cnt_sched (honours LS_HDR_EN).
module tb_ls_cnt_sched;

   localparam int unsigned NCH     = 4;
   localparam int unsigned CW      = 12;
   localparam int unsigned WIN_W   = 32;
   localparam int unsigned CLR_CYC = 4;

   logic              CLK = 1'b0;
   logic              RST = 1'b1;
   logic              start = 1'b0;
   logic              stop = 1'b0;
   logic              cont = 1'b0;
   logic [WIN_W-1:0]  win_len = '0;
   logic [NCH*CW-1:0] ch_err_cnt = '0;
   logic              rd_ready = 1'b0;
   logic [NCH-1:0]    ch_rst;
   logic              busy;
   logic              done;
   logic              rd_valid;
   logic [3:0]        rd_ch;
   logic [CW-1:0]     rd_cnt;
   logic              rd_hdr;
   logic [7:0]        run_id;

   ls_cnt_sched #(
      .NCH     (NCH),
      .CW      (CW),
      .WIN_W   (WIN_W),
      .CLR_CYC (CLR_CYC)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .start      (start),
      .stop       (stop),
      .cont       (cont),
      .win_len    (win_len),
      .ch_err_cnt (ch_err_cnt),
      .ch_rst     (ch_rst),
      .busy       (busy),
      .done       (done),
      .rd_valid   (rd_valid),
      .rd_ready   (rd_ready),
      .rd_ch      (rd_ch),
      .rd_cnt     (rd_cnt),
      .rd_hdr     (rd_hdr),
      .run_id     (run_id)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [3:0]    ch;
      logic [CW-1:0] cnt;
      logic          hdr;
      logic          last;
   } beat_t;

   beat_t      sb[$];
   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   int         rdy_mode = 0;
   logic [7:0] exp_runs = '0;
   logic [7:0] mon_runs = '0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [NCH*CW-1:0] rnd_bus();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[NCH*CW-1:0];
   endfunction

   task automatic finish_now();
      chk("scoreboard_empty", 64'(sb.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   endtask

   // Sink readiness: 0 = always ready, 1 = one cycle ready then three stalled, 2 = random.
   initial begin : rdy_gen
      int ph;
      ph = 0;
      forever begin
         @(posedge CLK);
         #1;
         if (rdy_mode == 0) rd_ready = 1'b1;
         else if (rdy_mode == 1) rd_ready = ((ph % 4) == 0);
         else rd_ready = 1'($urandom_range(0, 1));
         ph++;
      end
   end

   // Monitor: pops the expected beat on every acceptance, checks stall stability and done.
   initial begin : monitor
      beat_t      b;
      logic       exp_done;
      logic       stall_prev;
      logic [3:0] h_ch;
      logic [CW-1:0] h_cnt;
      logic       h_hdr;
      exp_done = 1'b0;
      stall_prev = 1'b0;
      h_ch = '0;
      h_cnt = '0;
      h_hdr = 1'b0;
      forever begin
         @(negedge CLK);
         if (RST) begin
            sb.delete();
            exp_done = 1'b0;
            stall_prev = 1'b0;
            mon_runs = '0;
         end else begin
            chk("done", done, exp_done);
            chk("run_id", run_id, mon_runs);
            exp_done = 1'b0;
            if (stall_prev) begin
               chk("stall_valid", rd_valid, 1);
               chk("stall_ch", rd_ch, h_ch);
               chk("stall_cnt", rd_cnt, h_cnt);
               chk("stall_hdr", rd_hdr, h_hdr);
            end
            if (rd_valid && rd_ready) begin
               if (sb.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_beat: got ch=%0d cnt=0x%0h, want no beat", rd_ch,
                           rd_cnt);
               end else begin
                  b = sb.pop_front();
                  chk("beat_ch", rd_ch, b.ch);
                  chk("beat_cnt", rd_cnt, b.cnt);
                  chk("beat_hdr", rd_hdr, b.hdr);
                  if (b.last) begin
                     exp_done = 1'b1;
                     mon_runs++;
                  end
               end
            end
            stall_prev = rd_valid && !rd_ready;
            h_ch = rd_ch;
            h_cnt = rd_cnt;
            h_hdr = rd_hdr;
         end
      end
   end

   // From the first CLR cycle: check clear/run timing, present the expected snapshot in the
   // SNAP cycle only, queue the expected beats, and return in the first drain cycle.
   task automatic clr_phase(input int w, input logic [NCH*CW-1:0] cb, input int stop_at,
                            input bit noise);
      int    eff;
      bit    ab;
      beat_t b;
      eff = (w == 0) ? 1 : w;
      ab = 1'b0;
      for (int i = 0; i < int'(CLR_CYC); i++) begin
         chk("ch_rst_clr", ch_rst, {NCH{1'b1}});
         chk("busy_clr", busy, 1);
         ch_err_cnt = rnd_bus();
         step();
      end
      chk("ch_rst_run", ch_rst, 0);
      chk("busy_run", busy, 1);
      for (int k = 0; k < eff; k++) begin
         ch_err_cnt = rnd_bus();
         if (noise) start = 1'($urandom_range(0, 1));
         if (k == stop_at) begin
            stop = 1'b1;
            ab = 1'b1;
         end
         step();
         start = 1'b0;
         stop = 1'b0;
         if (ab) break;
      end
      ch_err_cnt = cb;
`ifdef LS_HDR_EN
      b.ch = '0;
      b.cnt = CW'({ab, exp_runs});
      b.hdr = 1'b1;
      b.last = 1'b0;
      sb.push_back(b);
`endif
      for (int i = 0; i < int'(NCH); i++) begin
         b.ch = 4'(i);
         b.cnt = cb[i*CW +: CW];
         b.hdr = 1'b0;
         b.last = (i == int'(NCH) - 1);
         sb.push_back(b);
      end
      exp_runs++;
      step();
      chk("first_valid", rd_valid, 1);
      ch_err_cnt = rnd_bus();
   endtask

   task automatic single_run(input int w, input logic [NCH*CW-1:0] cb, input logic c,
                             input int stop_at, input bit noise, input bit stop_start);
      chk("idle_before_start", busy, 0);
      win_len = WIN_W'(w);
      cont = c;
      start = 1'b1;
      stop = stop_start;
      step();
      start = 1'b0;
      stop = 1'b0;
      cont = 1'b0;
      clr_phase(w, cb, stop_at, noise);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 400; i++) begin
         step();
         if (done) return;
      end
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done, want done within 400 cycles");
      finish_now();
   endtask

   initial begin : stim
      int t0;
      int w;
      RST = 1'b1;
      repeat (3) step();
      chk("rst_busy", busy, 0);
      chk("rst_ch_rst", ch_rst, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_ch", rd_ch, 0);
      chk("rst_rd_cnt", rd_cnt, 0);
      chk("rst_rd_hdr", rd_hdr, 0);
      chk("rst_run_id", run_id, 0);
      RST = 1'b0;
      step();

      // Directed run: window 10, fixed counts, sink always ready.
      rdy_mode = 0;
      step();
      t0 = cyc;
      single_run(10, {12'd7, 12'd4095, 12'd0, 12'd3}, 1'b0, -1, 1'b0, 1'b0);
      wait_done();
`ifdef LS_HDR_EN
      chk("done_latency", 64'(cyc - t0), 21);
`else
      chk("done_latency", 64'(cyc - t0), 20);
`endif
      chk("busy_after_done", busy, 0);
      chk("run_id_first", run_id, 1);

      // Stalling sink: one ready cycle in four.
      rdy_mode = 1;
      for (int r = 0; r < 2; r++) begin
         single_run($urandom_range(1, 12), rnd_bus(), 1'b0, -1, 1'b0, 1'b0);
         wait_done();
         chk("busy_after_stall_run", busy, 0);
      end

      // Zero window with start pulses while busy.
      rdy_mode = 2;
      single_run(0, rnd_bus(), 1'b0, -1, 1'b1, 1'b0);
      wait_done();
      chk("busy_after_win0", busy, 0);
      repeat (5) step();
      chk("still_idle_win0", busy, 0);

      // Continuous: three full runs, then stop mid-window of the fourth.
      single_run($urandom_range(1, 8), rnd_bus(), 1'b1, -1, 1'b0, 1'b0);
      for (int r = 2; r <= 4; r++) begin
         w = (r == 4) ? 8 : int'($urandom_range(1, 8));
         win_len = WIN_W'(w);
         wait_done();
         chk("cont_restart_ch_rst", ch_rst, {NCH{1'b1}});
         chk("cont_restart_busy", busy, 1);
         clr_phase(w, rnd_bus(), (r == 4) ? 3 : -1, 1'b0);
      end
      wait_done();
      chk("busy_after_stop_run", busy, 0);

      // start and stop together: start wins, run is not continuous.
      single_run(3, rnd_bus(), 1'b1, -1, 1'b0, 1'b1);
      wait_done();
      chk("busy_after_start_stop", busy, 0);

      // stop during drain of a continuous run: drain completes, then idle.
      single_run(2, rnd_bus(), 1'b1, -1, 1'b0, 1'b0);
      stop = 1'b1;
      step();
      stop = 1'b0;
      wait_done();
      chk("busy_after_drain_stop", busy, 0);

      // Reset while the third beat is offered.
      rdy_mode = 0;
      step();
      single_run(5, rnd_bus(), 1'b0, -1, 1'b0, 1'b0);
      step();
      step();
      RST = 1'b1;
      exp_runs = '0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_ch_rst", ch_rst, 0);
      chk("midrst_done", done, 0);
      chk("midrst_rd_valid", rd_valid, 0);
      chk("midrst_rd_ch", rd_ch, 0);
      chk("midrst_rd_cnt", rd_cnt, 0);
      chk("midrst_rd_hdr", rd_hdr, 0);
      chk("midrst_run_id", run_id, 0);
      step();
      RST = 1'b0;
      step();
      rdy_mode = 2;
      single_run(4, rnd_bus(), 1'b0, -1, 1'b0, 1'b0);
      wait_done();
      chk("run_id_after_rst", run_id, 1);

      // Run counter wrap.
      rdy_mode = 0;
      while (exp_runs != 8'd255) begin
         single_run(1, rnd_bus(), 1'b0, -1, 1'b0, 1'b0);
         wait_done();
      end
      chk("run_id_255", run_id, 255);
      single_run(1, rnd_bus(), 1'b0, -1, 1'b0, 1'b0);
      wait_done();
      chk("run_id_wrap", run_id, 0);
      chk("busy_after_wrap", busy, 0);

      // Random mix.
      for (int r = 0; r < 6; r++) begin
         rdy_mode = $urandom_range(0, 2);
         w = $urandom_range(0, 15);
         single_run(w, rnd_bus(), 1'b0, ($urandom_range(0, 2) == 0) ? 0 : -1, 1'b0, 1'b0);
         wait_done();
         chk("busy_after_rand", busy, 0);
      end
      repeat (3) step();
      finish_now();
   end

endmodule
